// File: rtl/grey_pkg.sv
// -----------------------------------------------------------------------------
// grey_pkg
// Shared helpers for grey-coded buses: bin2grey / grey2bin / popcount and the
// receive-side FSM state type. Used by grey_code (transmit side) and by
// grey_sync_rx / grey_to_binary (receive side).
//
// The functions work on zero-extended MAX_W-bit values. Leading zeros do not
// change a grey<->binary conversion or a popcount, so any bus width up to
// MAX_W works. Callers cast in with MAX_W'(x) and truncate the result back
// to their own width.
// -----------------------------------------------------------------------------
package grey_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        INIT = 1'b0,   // filling the synchroniser, no valid samples yet
        RUN  = 1'b1    // baseline captured, tracking changes
    } sync_state_t;

    function automatic logic [MAX_W-1:0] bin2grey(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]
    function automatic logic [MAX_W-1:0] grey2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = '0;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] x);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (x[i]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/grey_to_binary.sv
// -----------------------------------------------------------------------------
// grey_to_binary
// Combinational grey -> binary converter, the receive-side counterpart of
// grey_code.
//
// Ports:
//   grey  in  SIZE  grey-coded value
//   bin   out SIZE  binary equivalent
// -----------------------------------------------------------------------------
module grey_to_binary
    import grey_pkg::*;
#(
    parameter int SIZE = 3
) (
    input  logic [SIZE-1:0] grey,
    output logic [SIZE-1:0] bin
);

    logic [MAX_W-1:0] bin_wide;

    assign bin_wide = grey2bin(MAX_W'(grey));
    assign bin      = bin_wide[SIZE-1:0];

endmodule

// File: rtl/grey_sync_rx.sv
// -----------------------------------------------------------------------------
// grey_sync_rx
// Receive stage for a grey-coded bus from another timing domain. Synchronises
// grey_in through SYNC_STAGES flops, converts it to binary and reports every
// change with a one-cycle bin_valid pulse plus the modular step size (delta).
// A sample that differs from the previous one in more than one bit is still
// accepted, but raises multi_bit_err and latches err_sticky.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   grey_in        in   SIZE  grey-coded value, asynchronous to clk
//   clr_err        in   clears err_sticky (a same-cycle new error wins)
//   bin_out        out  SIZE  binary value of the last accepted sample
//   bin_valid      out  one-cycle pulse: bin_out took a new value
//   delta          out  SIZE  (new - previous) mod 2^SIZE
//   multi_bit_err  out  one-cycle pulse: accepted sample changed >1 bit
//   err_sticky     out  latched OR of multi_bit_err since reset/clear
//   ready          out  high once the synchroniser is primed
// -----------------------------------------------------------------------------
module grey_sync_rx
    import grey_pkg::*;
#(
    parameter int SIZE        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] grey_in,
    input  logic            clr_err,
    output logic [SIZE-1:0] bin_out,
    output logic            bin_valid,
    output logic [SIZE-1:0] delta,
    output logic            multi_bit_err,
    output logic            err_sticky,
    output logic            ready
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Synchroniser: plain flop chain, nothing between stages.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][SIZE-1:0] sync_chain;
    logic [SIZE-1:0]                  sync_q;
    logic [SIZE-1:0]                  sync_bin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], grey_in};
        end
    end

    assign sync_q = sync_chain[SYNC_STAGES-1];

    grey_to_binary #(
        .SIZE (SIZE)
    ) u_g2b (
        .grey (sync_q),
        .bin  (sync_bin)
    );

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    sync_state_t      state_q, state_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [SIZE-1:0]  prev_grey, prev_grey_d;
    logic [SIZE-1:0]  bin_d, delta_d;
    logic             valid_d, mbe_d, sticky_d, ready_d;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        prev_grey_d = prev_grey;
        bin_d       = bin_out;
        delta_d     = delta;
        valid_d     = 1'b0;
        mbe_d       = 1'b0;
        ready_d     = ready;

        unique case (state_q)
            INIT: begin
                // Once the chain holds a real sample, take it as the
                // baseline silently: no pulse and no error check.
                if (fill_q == CNT_W'(SYNC_STAGES)) begin
                    prev_grey_d = sync_q;
                    bin_d       = sync_bin;
                    delta_d     = '0;
                    state_d     = RUN;
                    ready_d     = 1'b1;
                end else begin
                    fill_d = fill_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (sync_q != prev_grey) begin
                    prev_grey_d = sync_q;
                    bin_d       = sync_bin;
                    delta_d     = sync_bin - bin_out;   // wraps mod 2^SIZE
                    valid_d     = 1'b1;
                    mbe_d       = popcount(MAX_W'(sync_q ^ prev_grey)) > 32'd1;
                end
            end
            default: state_d = INIT;
        endcase

        // A new error takes priority over a same-cycle clear.
        sticky_d = mbe_d | (err_sticky & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= INIT;
            fill_q        <= '0;
            prev_grey     <= '0;
            bin_out       <= '0;
            delta         <= '0;
            bin_valid     <= 1'b0;
            multi_bit_err <= 1'b0;
            err_sticky    <= 1'b0;
            ready         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            prev_grey     <= prev_grey_d;
            bin_out       <= bin_d;
            delta         <= delta_d;
            bin_valid     <= valid_d;
            multi_bit_err <= mbe_d;
            err_sticky    <= sticky_d;
            ready         <= ready_d;
        end
    end

endmodule

// File: tb/tb_grey_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_grey_sync_rx
// Two DUT configurations (SIZE=3/SYNC_STAGES=2 and SIZE=6/SYNC_STAGES=3),
// each with its own driver and monitor. The receiver is modelled as: "the
// value driven for edge n is reported at edge n+SYNC_STAGES; the value
// driven for the first edge after reset is the silent baseline". The driver
// pushes expected events into a queue and the monitor pops them when due.
// -----------------------------------------------------------------------------
module tb_grey_sync_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int en;      // edge index (since reset release) the event is due
        bit base;    // baseline capture rather than a change pulse
        int bin;
        int delta;
        bit err;
    } exp_t;

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = g; s != 0; s = s >> 1) b = b ^ s;
        return b;
    endfunction

    task automatic chk(input bit ok, input string nm, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int SZ  = (k == 0) ? 3 : 6;
        localparam int SS  = (k == 0) ? 2 : 3;
        localparam int MSK = (1 << SZ) - 1;

        logic          rst_n = 1'b0;
        logic [SZ-1:0] grey_in = '0;
        logic          clr_err = 1'b0;
        logic [SZ-1:0] bin_out, delta;
        logic          bin_valid, multi_bit_err, err_sticky, ready;

        grey_sync_rx #(.SIZE(SZ), .SYNC_STAGES(SS)) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .grey_in       (grey_in),
            .clr_err       (clr_err),
            .bin_out       (bin_out),
            .bin_valid     (bin_valid),
            .delta         (delta),
            .multi_bit_err (multi_bit_err),
            .err_sticky    (err_sticky),
            .ready         (ready)
        );

        exp_t q[$];
        int   m = 0;           // edges since reset release (monitor-owned)
        int   last_g = 0;
        int   cur = 0;
        bit   done = 0;

        // ---------------- driver ----------------
        task automatic reset_for(input int v, input int cycles);
            for (int i = 0; i < cycles; i++) begin
                @(negedge clk);
                rst_n   = 1'b0;
                grey_in = SZ'(v);
                clr_err = 1'b0;
                q.delete();
            end
            cur = v;
        endtask

        task automatic drive(input int v, input bit c);
            int n;
            exp_t e;
            @(negedge clk);
            rst_n   = 1'b1;
            grey_in = SZ'(v);
            clr_err = c;
            n = m + 1;
            if (n == 1) begin
                e = '{en: n + SS, base: 1'b1, bin: g2b(v), delta: 0, err: 1'b0};
                q.push_back(e);
            end else if (v != last_g) begin
                e = '{en: n + SS, base: 1'b0, bin: g2b(v),
                      delta: (g2b(v) - g2b(last_g)) & MSK,
                      err: $countones(v ^ last_g) > 1};
                q.push_back(e);
            end
            last_g = v;
            cur    = v;
        endtask

        task automatic hold(input int v, input int cycles);
            for (int i = 0; i < cycles; i++) drive(v, 1'b0);
        endtask

        task automatic random_run(input int cycles);
            int r, b;
            for (int i = 0; i < cycles; i++) begin
                r = $urandom_range(0, 7);
                b = g2b(cur);
                case (r)
                    3, 4:    b = (b + 1) & MSK;
                    5:       b = (b - 1) & MSK;
                    default: ;
                endcase
                if (r >= 3 && r <= 5) cur = b2g(b);
                else if (r == 6) cur = cur ^ (1 << $urandom_range(0, SZ - 1));
                else if (r == 7) cur = $urandom_range(0, MSK);
                drive(cur, $urandom_range(0, 7) == 0);
            end
        endtask

        initial begin
            // prime on a held value: baseline bin 3, ready after SS+1 edges
            reset_for(b2g(3), 2);
            hold(b2g(3), SS + 3);
            // count sweep, 4 cycles per value, then wrap max -> 0
            for (int b = 0; b <= MSK; b++) hold(b2g(b), 4);
            hold(b2g(0), SS + 3);
            // illegal jump 000 -> 011
            hold(3, SS + 3);
            // 011 -> 101 (two bits) with clr_err on the edge the error lands
            for (int i = 0; i < SS; i++) drive(5, 1'b0);
            drive(5, 1'b1);
            hold(5, SS + 2);
            drive(5, 1'b1);                 // clear alone
            hold(5, 2);
            random_run(150);
            // reset mid-run at bin 5, then re-prime on the same input
            hold(b2g(5), SS + 3);
            reset_for(b2g(5), 1);
            hold(b2g(5), SS + 4);
            random_run(60);
            hold(cur, SS + 3);
            chk(q.size() == 0, $sformatf("queue_drained_%0d", k), q.size(), 0);
            done = 1'b1;
        end

        // ---------------- monitor ----------------
        initial begin
            bit   r, c, err_now;
            bit   sticky_m = 1'b0;
            exp_t e;
            forever begin
                @(posedge clk);
                r = rst_n;
                c = clr_err;
                if (!r) m = 0;
                else    m = m + 1;
                #1;
                if (!r) begin
                    sticky_m = 1'b0;
                    chk(bin_out == '0 && delta == '0 && !bin_valid && !multi_bit_err
                        && !err_sticky && !ready, $sformatf("reset_state_%0d", k),
                        int'({bin_out, delta, bin_valid, multi_bit_err, err_sticky, ready}), 0);
                end else begin
                    chk(ready == (m >= SS + 1), $sformatf("ready_%0d", k), int'(ready),
                        int'(m >= SS + 1));
                    err_now = 1'b0;
                    if (q.size() > 0 && q[0].en == m) begin
                        e = q.pop_front();
                        if (e.base) begin
                            chk(!bin_valid && !multi_bit_err, $sformatf("base_no_pulse_%0d", k),
                                int'(bin_valid), 0);
                            chk(int'(bin_out) == e.bin, $sformatf("base_bin_%0d", k),
                                int'(bin_out), e.bin);
                            chk(delta == '0, $sformatf("base_delta_%0d", k), int'(delta), 0);
                        end else begin
                            err_now = e.err;
                            chk(bin_valid, $sformatf("valid_%0d", k), int'(bin_valid), 1);
                            chk(int'(bin_out) == e.bin, $sformatf("bin_%0d", k),
                                int'(bin_out), e.bin);
                            chk(int'(delta) == e.delta, $sformatf("delta_%0d", k),
                                int'(delta), e.delta);
                            chk(multi_bit_err == e.err, $sformatf("mbe_%0d", k),
                                int'(multi_bit_err), int'(e.err));
                        end
                    end else begin
                        chk(!bin_valid && !multi_bit_err, $sformatf("spurious_pulse_%0d", k),
                            int'({bin_valid, multi_bit_err}), 0);
                        if (q.size() > 0 && q[0].en < m) begin
                            chk(1'b0, $sformatf("missed_event_%0d", k), m, q[0].en);
                            void'(q.pop_front());
                        end
                    end
                    sticky_m = err_now ? 1'b1 : (c ? 1'b0 : sticky_m);
                    chk(err_sticky == sticky_m, $sformatf("sticky_%0d", k),
                        int'(err_sticky), int'(sticky_m));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(g_cfg[0].done && g_cfg[1].done); i++) @(posedge clk);
        chk(g_cfg[0].done && g_cfg[1].done, "timeout", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
